// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared types and constants for the RISC-V instruction fetch stage.
//
// Contents:
//   fetch_state_t  : fetch FSM states (IDLE, AR, R, RESP)
//   FETCH_ARPROT   : AXI ARPROT for instruction fetches (instruction, secure, unprivileged)
//   AXI_RESP_OKAY  : AXI OKAY response code
//   select_half()  : picks the 32-bit instruction out of a 64-bit memory word
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RESP = 2'd3
    } fetch_state_t;

    localparam logic [2:0] FETCH_ARPROT  = 3'b100;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // PC[2] chooses the instruction within the 8-byte word (little-endian).
    function automatic logic [31:0] select_half(input logic [63:0] word, input logic upper);
        return upper ? word[63:32] : word[31:0];
    endfunction

endpackage

// File: rtl/riscv_fetch_line_buf.sv
// riscv_fetch_line_buf -- single-line instruction buffer holding one 64-bit
// memory word (two instructions) and its tag. Only instantiated when
// RISCV_FETCH_LINE_BUF_EN is defined.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (clears valid and tag)
//   lookup_tag  : tag of the address being looked up
//   hit         : valid && tag match && not being invalidated this cycle
//   hit_data    : stored 64-bit word
//   fill        : write fill_tag / fill_data and set valid
//   fill_tag    : tag to store
//   fill_data   : word to store
//   inval       : clear valid (flush or bus error); wins over fill and hit
module riscv_fetch_line_buf #(
    parameter int TAG_WIDTH  = 61,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TAG_WIDTH-1:0]  lookup_tag,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_data,
    input  logic                  fill,
    input  logic [TAG_WIDTH-1:0]  fill_tag,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  inval
);

    logic                  valid_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else if (inval) begin
            valid_q <= 1'b0;
        end else if (fill) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag;
        end
    end

    // NOTE: the data word is never read while valid_q is 0, so it needs no
    // reset; leaving it out of the reset network keeps it a plain register bank.
    always_ff @(posedge clk) begin
        if (fill && !inval) begin
            data_q <= fill_data;
        end
    end

    // A flush coincident with the lookup must turn the hit into a miss.
    assign hit      = valid_q && (tag_q == lookup_tag) && !inval;
    assign hit_data = data_q;

endmodule

// File: rtl/riscv_instr_fetch.sv
// riscv_instr_fetch -- instruction fetch stage in front of the RISC-V core.
// Takes a PC + read strobe, fetches the containing 64-bit word over an
// AXI-Lite read-only master (one transaction outstanding) and returns one
// 32-bit instruction with a single-cycle valid pulse.
//
// Build option: RISCV_FETCH_LINE_BUF_EN -- when defined, a one-line buffer
// serves both halves of the last fetched word; when undefined every aligned
// fetch goes to the bus and i_flush is ignored.
//
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   enable               : global enable; low freezes all state
//   i_read_instr, i_pc   : fetch request strobe and address
//   i_flush              : invalidate line buffer
//   o_instr, o_instr_valid, o_fetch_err : response (pulse), error qualifier
//   o_busy               : fetch in progress, new requests not accepted
//   o_araddr/o_arprot/o_arvalid/i_arready : AXI-Lite AR channel
//   i_rdata/i_rresp/i_rvalid/o_rready     : AXI-Lite R channel
module riscv_instr_fetch
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   i_read_instr,
    input  logic [ADDR_WIDTH-1:0]  i_pc,
    input  logic                   i_flush,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic                   o_instr_valid,
    output logic                   o_fetch_err,
    output logic                   o_busy,
    output logic [ADDR_WIDTH-1:0]  o_araddr,
    output logic [2:0]             o_arprot,
    output logic                   o_arvalid,
    input  logic                   i_arready,
    input  logic [DATA_WIDTH-1:0]  i_rdata,
    input  logic [1:0]             i_rresp,
    input  logic                   i_rvalid,
    output logic                   o_rready
);

    localparam int TAG_WIDTH = ADDR_WIDTH - 3;

    fetch_state_t state, state_next;

    logic                   half_q;      // PC[2] of the outstanding bus fetch
    logic [INSTR_WIDTH-1:0] pend_instr;  // response staged while in RESP
    logic                   pend_err;
    logic                   valid_q;
    logic                   err_q;

    logic                  misaligned;
    logic                  r_beat;
    logic                  bus_err;
    logic                  hit;
    logic [DATA_WIDTH-1:0] hit_data;

    assign misaligned = (i_pc[1:0] != 2'b00);
    assign r_beat     = enable && (state == R) && i_rvalid;
    assign bus_err    = r_beat && (i_rresp != AXI_RESP_OKAY);

`ifdef RISCV_FETCH_LINE_BUF_EN
    logic flush_seen;  // a flush arrived while this fetch was on the bus
    logic buf_inval;
    logic buf_fill;

    assign buf_inval = (enable && i_flush) || bus_err;
    assign buf_fill  = r_beat && !bus_err && !flush_seen && !i_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_seen <= 1'b0;
        end else if (enable) begin
            if (state == IDLE && i_read_instr) begin
                flush_seen <= 1'b0;
            end else if ((state == AR || state == R) && i_flush) begin
                flush_seen <= 1'b1;
            end
        end
    end

    riscv_fetch_line_buf #(
        .TAG_WIDTH (TAG_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_line_buf (
        .clk       (clk),
        .reset     (reset),
        .lookup_tag(i_pc[ADDR_WIDTH-1:3]),
        .hit       (hit),
        .hit_data  (hit_data),
        .fill      (buf_fill),
        .fill_tag  (o_araddr[ADDR_WIDTH-1:3]),
        .fill_data (i_rdata),
        .inval     (buf_inval)
    );
`else
    logic unused_flush;
    assign unused_flush = i_flush;
    assign hit          = 1'b0;
    assign hit_data     = '0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state and busy ----------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        o_busy     = (state != IDLE);
        if (enable) begin
            unique case (state)
                IDLE: begin
                    if (i_read_instr) begin
                        o_busy     = 1'b1;
                        state_next = (misaligned || hit) ? RESP : AR;
                    end
                end
                AR:   if (i_arready) state_next = R;
                R:    if (i_rvalid)  state_next = RESP;
                RESP: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ---------------- Datapath and bus outputs ----------------
    // NOTE: registers are written with non-blocking assignments so every
    // read in this block sees the value from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_araddr   <= '0;
            o_arvalid  <= 1'b0;
            o_rready   <= 1'b0;
            o_instr    <= '0;
            half_q     <= 1'b0;
            pend_instr <= '0;
            pend_err   <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Response flags are pulses: they drop on the next edge even
            // while disabled, so a pulse is never stretched.
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (enable) begin
                unique case (state)
                    IDLE: begin
                        if (i_read_instr) begin
                            if (misaligned) begin
                                pend_instr <= '0;
                                pend_err   <= 1'b1;
                            end else if (hit) begin
                                pend_instr <= select_half(hit_data, i_pc[2]);
                                pend_err   <= 1'b0;
                            end else begin
                                o_araddr  <= {i_pc[ADDR_WIDTH-1:3], 3'b000};
                                o_arvalid <= 1'b1;
                                half_q    <= i_pc[2];
                            end
                        end
                    end
                    AR: begin
                        if (i_arready) begin
                            o_arvalid <= 1'b0;
                            o_rready  <= 1'b1;
                        end
                    end
                    R: begin
                        if (i_rvalid) begin
                            o_rready   <= 1'b0;
                            pend_instr <= select_half(i_rdata, half_q);
                            pend_err   <= (i_rresp != AXI_RESP_OKAY);
                        end
                    end
                    RESP: begin
                        o_instr <= pend_instr;
                        valid_q <= 1'b1;
                        err_q   <= pend_err;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_instr_valid = valid_q && enable;
    assign o_fetch_err   = err_q && enable;
    assign o_arprot      = FETCH_ARPROT;

`ifndef SYNTHESIS
    // The core must wait for o_busy to drop before issuing another request.
    a_no_req_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(enable && i_read_instr && state != IDLE));
`endif

endmodule

// File: tb/tb_riscv_instr_fetch.sv
// tb_riscv_instr_fetch -- directed self-checking bench for riscv_instr_fetch.
// Works with and without RISCV_FETCH_LINE_BUF_EN; expectations switch on the
// same macro. The bench plays the AXI-Lite slave cycle by cycle.
module tb_riscv_instr_fetch;

`ifdef RISCV_FETCH_LINE_BUF_EN
    localparam bit LB_EN = 1'b1;
`else
    localparam bit LB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        i_read_instr;
    logic [63:0] i_pc;
    logic        i_flush;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic        o_fetch_err;
    logic        o_busy;
    logic [63:0] o_araddr;
    logic [2:0]  o_arprot;
    logic        o_arvalid;
    logic        i_arready;
    logic [63:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid;
    logic        o_rready;

    int n_checks = 0;
    int n_errors = 0;

    riscv_instr_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .i_read_instr (i_read_instr),
        .i_pc         (i_pc),
        .i_flush      (i_flush),
        .o_instr      (o_instr),
        .o_instr_valid(o_instr_valid),
        .o_fetch_err  (o_fetch_err),
        .o_busy       (o_busy),
        .o_araddr     (o_araddr),
        .o_arprot     (o_arprot),
        .o_arvalid    (o_arvalid),
        .i_arready    (i_arready),
        .i_rdata      (i_rdata),
        .i_rresp      (i_rresp),
        .i_rvalid     (i_rvalid),
        .o_rready     (o_rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One fetch: request pulse in cycle 0, then act as AXI slave. ar_wait is
    // the number of AR cycles with arready low; rvalid answers immediately.
    // Latency counts cycles from the request cycle to the valid cycle.
    task automatic fetch(input string name, input logic [63:0] pc, input int ar_wait,
                         input logic [63:0] rdata, input logic [1:0] rresp,
                         input bit flush_req, input bit flush_r, input bit exp_ar,
                         input logic [31:0] exp_instr, input bit exp_err, input int exp_lat);
        int lat;
        int got_lat;
        int ar_cnt;
        bit got;
        bit ar_seen;
        logic [63:0] exp_addr;
        exp_addr = {pc[63:3], 3'b000};
        lat = 1; got = 1'b0; ar_seen = 1'b0; ar_cnt = 0; got_lat = 0;

        @(posedge clk); #1;
        i_read_instr = 1'b1; i_pc = pc; i_flush = flush_req;
        @(posedge clk); #1;
        i_read_instr = 1'b0; i_flush = 1'b0;

        while (!got && lat <= 30) begin
            i_arready = 1'b0; i_rvalid = 1'b0; i_flush = 1'b0;
            if (o_arvalid) begin
                ar_seen = 1'b1;
                check({name, ".araddr"}, o_araddr, exp_addr);
                if (ar_cnt >= ar_wait) i_arready = 1'b1;
                ar_cnt++;
            end
            if (o_rready) begin
                i_rvalid = 1'b1; i_rdata = rdata; i_rresp = rresp; i_flush = flush_r;
            end
            if (lat == 1) check({name, ".busy"}, {63'd0, o_busy}, 64'd1);
            @(negedge clk);
            if (o_instr_valid) begin
                got = 1'b1;
                got_lat = lat;
                check({name, ".instr"}, {32'd0, o_instr}, {32'd0, exp_instr});
                check({name, ".err"}, {63'd0, o_fetch_err}, {63'd0, exp_err});
            end
            @(posedge clk); #1;
            lat++;
        end
        i_arready = 1'b0; i_rvalid = 1'b0; i_flush = 1'b0;

        check({name, ".done"}, {63'd0, got}, 64'd1);
        check({name, ".lat"}, got_lat, exp_lat);
        check({name, ".ar_issued"}, {63'd0, ar_seen}, {63'd0, exp_ar});
        check({name, ".pulse_end"}, {63'd0, o_instr_valid}, 64'd0);
    endtask

    localparam logic [63:0] W1000 = 64'h00500093_00100093;
    localparam logic [63:0] W2000 = 64'h11111111_22222222;

    initial begin
        reset = 1'b1; enable = 1'b1; i_read_instr = 1'b0; i_pc = '0; i_flush = 1'b0;
        i_arready = 1'b0; i_rdata = '0; i_rresp = 2'b00; i_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.instr",  {32'd0, o_instr}, 64'd0);
        check("rst.valid",  {63'd0, o_instr_valid}, 64'd0);
        check("rst.err",    {63'd0, o_fetch_err}, 64'd0);
        check("rst.busy",   {63'd0, o_busy}, 64'd0);
        check("rst.araddr", o_araddr, 64'd0);
        check("rst.arvalid",{63'd0, o_arvalid}, 64'd0);
        check("rst.rready", {63'd0, o_rready}, 64'd0);
        check("arprot",     {61'd0, o_arprot}, 64'd4);
        @(posedge clk); #1 reset = 1'b0;

        // Aligned miss, then the other half of the same word.
        fetch("miss_1000", 64'h1000, 0, W1000, 2'b00, 0, 0, 1, 32'h00100093, 0, 4);
        fetch("hit_1004",  64'h1004, 0, W1000, 2'b00, 0, 0, !LB_EN, 32'h00500093, 0,
              LB_EN ? 2 : 4);

        // Misaligned: error, zero instruction, no bus access.
        fetch("misal_1002", 64'h1002, 0, W1000, 2'b00, 0, 0, 0, 32'h0, 1, 2);

        // AR backpressure for 5 cycles, then SLVERR; buffer must be dropped.
        fetch("slverr_1008", 64'h1008, 5, 64'hCAFEF00D_DEADBEEF, 2'b10, 0, 0, 1,
              32'hDEADBEEF, 1, 9);
        fetch("after_err_100c", 64'h100C, 0, 64'h0000A0B7_00000013, 2'b00, 0, 0, 1,
              32'h0000A0B7, 0, 4);
        fetch("after_err_1004", 64'h1004, 0, W1000, 2'b00, 0, 0, 1, 32'h00500093, 0, 4);

        // Flush during R: data still returned, line not kept.
        fetch("flush_r_2000", 64'h2000, 0, W2000, 2'b00, 0, 1, 1, 32'h22222222, 0, 4);
        fetch("post_flush_2004", 64'h2004, 0, W2000, 2'b00, 0, 0, 1, 32'h11111111, 0, 4);
        fetch("refill_hit_2000", 64'h2000, 0, W2000, 2'b00, 0, 0, !LB_EN, 32'h22222222, 0,
              LB_EN ? 2 : 4);

        // Flush coincident with what would be a hit: treated as a miss.
        fetch("flush_req_2004", 64'h2004, 0, W2000, 2'b00, 1, 0, 1, 32'h11111111, 0, 4);

        // Disabled: a request is ignored entirely.
        @(posedge clk); #1;
        enable = 1'b0; i_read_instr = 1'b1; i_pc = 64'h4000;
        @(posedge clk); #1;
        i_read_instr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("dis.arvalid", {63'd0, o_arvalid}, 64'd0);
            check("dis.valid",   {63'd0, o_instr_valid}, 64'd0);
            check("dis.busy",    {63'd0, o_busy}, 64'd0);
        end
        @(posedge clk); #1 enable = 1'b1;

        // Reset while in AR drops the bus outputs immediately.
        @(posedge clk); #1;
        i_read_instr = 1'b1; i_pc = 64'h3000;
        @(posedge clk); #1;
        i_read_instr = 1'b0;
        check("rst_ar.arvalid_before", {63'd0, o_arvalid}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_ar.arvalid", {63'd0, o_arvalid}, 64'd0);
        check("rst_ar.busy",    {63'd0, o_busy}, 64'd0);
        check("rst_ar.rready",  {63'd0, o_rready}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        fetch("rst_refetch_3000", 64'h3000, 0, 64'h00000000_00208033, 2'b00, 0, 0, 1,
              32'h00208033, 0, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
